// File: rtl/sync_hs_rx.sv
// 4-phase handshake receiver: synchronizes req_i into clk_s, captures data_i
// into a one-word output buffer and acknowledges, with backpressure and error flag.
module sync_hs_rx #(
   parameter int unsigned DW          = 8,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic          clk_s,
   input  logic          rst_s,
   input  logic          req_i,
   input  logic [DW-1:0] data_i,
   output logic          ack_o,
   output logic [DW-1:0] data_o,
   output logic          valid_o,
   input  logic          ready_i,
   output logic [15:0]   xfer_cnt_o,
   output logic          err_o
);

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   req_s;
   logic                   req_s_prev_q;
   logic                   buf_free;
   logic                   capture;
   logic                   withdraw;
   logic                   ack_q, ack_d;
   logic                   valid_q, valid_d;
   logic [DW-1:0]          data_q, data_d;
   logic [15:0]            cnt_q, cnt_d;
   logic                   err_q, err_d;

   always_comb begin
      req_s    = sync_q[SYNC_STAGES-1];
      buf_free = !valid_q || ready_i;
      capture  = (state_q == IDLE) && req_s && buf_free;
      // Request seen last cycle but gone before it was ever acknowledged.
      withdraw = (state_q == IDLE) && !req_s && req_s_prev_q;

      state_d = state_q;
      case (state_q)
         IDLE:    if (capture) state_d = ACK;
         ACK:     if (!req_s)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ack_d = (state_d == ACK);

      valid_d = valid_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      if (capture) begin
         valid_d = 1'b1;
         data_d  = data_i;
         cnt_d   = cnt_q + 16'd1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end

      err_d = err_q || withdraw;
   end

   always_ff @(posedge clk_s) begin
      if (rst_s) begin
         sync_q       <= '0;
         req_s_prev_q <= 1'b0;
         state_q      <= IDLE;
         ack_q        <= 1'b0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         cnt_q        <= '0;
         err_q        <= 1'b0;
      end else begin
         sync_q       <= {sync_q[SYNC_STAGES-2:0], req_i};
         req_s_prev_q <= req_s;
         state_q      <= state_d;
         ack_q        <= ack_d;
         valid_q      <= valid_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign ack_o      = ack_q;
   assign valid_o    = valid_q;
   assign data_o     = data_q;
   assign xfer_cnt_o = cnt_q;
   assign err_o      = err_q;

endmodule

// File: doc/sync_hs_rx.md
SYNC_HS_RX -- requirements
Module: sync_hs_rx

Interface
REQ-001: Parameter DW, default 8, is the width of the transferred data word.
REQ-002: Parameter SYNC_STAGES, default 2, minimum 2, is the flop count of the req_i synchronizer.
REQ-003: clk_s  input  1  destination-domain clock, the only clock in the block.
REQ-004: rst_s  input  1  reset; synchronous and active-high.
REQ-005: req_i  input  1  4-phase request level from the source domain, asynchronous to clk_s.
REQ-006: data_i  input  DW  source data; stable whenever req_i is high.
REQ-007: ack_o  output  1  4-phase acknowledge level back to the source domain; registered.
REQ-008: data_o  output  DW  captured word; registered.
REQ-009: valid_o  output  1  data_o holds an unconsumed word.
REQ-010: ready_i  input  1  downstream accepts data_o this cycle when valid_o is 1.
REQ-011: xfer_cnt_o  output  16  count of completed captures; wraps 0xFFFF->0x0000.
REQ-012: err_o  output  1  sticky protocol-violation flag.

Function
REQ-013: req_i shall pass through SYNC_STAGES flops clocked by clk_s; only the last stage (req_s) is used by the logic.
REQ-014: FSM states: IDLE (ack_o=0) and ACK (ack_o=1); ack_o is a registered copy of the state.
REQ-015: IDLE->ACK when req_s=1 and buffer free (valid_o=0, or valid_o=1 with ready_i=1) in the same cycle.
REQ-016: On the IDLE->ACK edge: data_o<=data_i, valid_o<=1, xfer_cnt_o increments by 1.
REQ-017: ACK->IDLE when req_s=0; no capture occurs in ACK.
REQ-018: In IDLE with req_s=1 and buffer not free, the FSM stays in IDLE with ack_o=0 (backpressure reaches the source).
REQ-019: valid_o clears on a cycle with valid_o=1 and ready_i=1 unless a capture occurs on the same edge; capture has priority and valid_o stays 1.
REQ-020: data_o is only written on capture; it is unchanged otherwise, including after valid_o clears.
REQ-021: Latency: req_i rising before clk_s edge 1 with the buffer free gives req_s=1 after edge SYNC_STAGES, and valid_o=1, ack_o=1 after edge SYNC_STAGES+1.
REQ-022: ack_o falls one edge after req_s falls; a new req_s rise is not captured before the FSM has returned to IDLE.
REQ-023: err_o sets when req_s goes 1->0 while in IDLE and the previous cycle's req_s was 1. This is a request withdrawn before its acknowledge. err_o clears only on reset.
REQ-024: The withdrawn request in REQ-023 shall not be captured and shall not change xfer_cnt_o.

Reset
REQ-025: While rst_s=1 at a clk_s edge, the following shall become 0 on that edge: all synchronizer flops, the FSM (to IDLE), ack_o, valid_o, data_o, xfer_cnt_o and err_o.
REQ-026: Reset in ACK shall drop ack_o on the reset edge. A req_i still high after reset release shall be treated as a new request (recaptured).
REQ-027: ready_i and data_i are ignored during reset.

Verification
REQ-028: SYNC_STAGES=2, ready_i=1, req_i rises with data_i=0xA5 -> valid_o=1, data_o=0xA5 and ack_o=1 after edge 3; xfer_cnt_o=1; valid_o=0 after edge 4.
REQ-029: Drop req_i after ack_o -> ack_o=0 three edges later. Raise req_i again with data_i=0x3C -> second capture, xfer_cnt_o=2.
REQ-030: ready_i=0, first word 0x11 captured, second req_i raised -> ack_o stays 0 and data_o stays 0x11. Pulse ready_i for 1 cycle -> 0x22 is captured on that same edge and valid_o stays 1.
REQ-031: req_i high 1 cycle during backpressure, then low -> err_o=1 and sticky; no capture; xfer_cnt_o unchanged.
REQ-032: Assert rst_s while in ACK with valid_o=1 -> all outputs 0 on the next edge. With req_i still high after release -> recapture after SYNC_STAGES+1 edges.
REQ-033: 65536 back-to-back transfers -> xfer_cnt_o wraps to 0x0000 with no err_o.
